mux2_sel_arbiter: RTL and testbench
===================================

// Module: mux2_sel_arbiter
// PURPOSE
//  Round-robin arbiter that owns the select line of the downstream 2:1 data mux.
//  Two sources request the shared mux output. The arbiter grants one source at a time
//  and drives s to the mux: s=0 selects i0/source 0, s=1 selects i1/source 1.
//  The grant is held until the owner signals done, so s never changes mid-transfer.
// PARAMETERS
//  HOLD_MAX  15  max cycles an owner may hold the grant (used only with timeout feature)
//  CNT_W     4   hold-counter width; HOLD_MAX must be < 2**CNT_W
// PORTS
//  clk      in   1  single clock; all state updates on rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  req0     in   1  source 0 requests the mux
//  req1     in   1  source 1 requests the mux
//  done     in   1  current owner finished; releases the grant
//  s        out  1  registered mux select (0=i0, 1=i1)
//  gnt0     out  1  source 0 owns the mux
//  gnt1     out  1  source 1 owns the mux
//  busy     out  1  gnt0|gnt1
//  timeout  out  1  1-cycle pulse on forced release; tied 0 when the feature is compiled out
// BEHAVIOUR
//  - All outputs registered. Reset (async on rst_n=0) forces state IDLE, s=0, gnt0=gnt1=0,
//    busy=0, timeout=0, last=1, hold counter=0. Outputs drop on reset assertion, not at the next edge.
//  - last: internal flag holding the most recent owner. After reset source 0 wins the first tie.
//  - States: IDLE, OWN0, OWN1. gnt0=1 only in OWN0. gnt1=1 only in OWN1. gnt0&gnt1 is never 1.
//  - IDLE:
//    - req0&req1 -> grant ~last.
//    - req0 only -> OWN0. req1 only -> OWN1.
//    - Latency req->gnt: 1 cycle.
//  - OWNx release event: done=1, or reqx=0, or timeout (feature on).
//    - Other source requesting -> OWN(other) next cycle, with no IDLE bubble.
//    - Else reqx still 1 -> stay OWNx (re-grant). The hold counter restarts.
//    - Else -> IDLE.
//  - done is ignored in IDLE. done and a new request in the same cycle: done releases
//    first, then the request is arbitrated in the same edge.
//  - s = 0 in OWN0, 1 in OWN1. In IDLE s holds its last value so the mux output does not toggle.
//  - last updates whenever entering OWN0/OWN1.
//  - Hold counter: 0 on grant entry, +1 per cycle in OWNx. It saturates at HOLD_MAX and does not wrap.
// CONFIGURATION
//  MUX2_SEL_TIMEOUT_EN defined:
//    - When the counter reaches HOLD_MAX with done=0, a forced release occurs, treated exactly as done=1.
//    - timeout pulses high for that 1 cycle.
//  MUX2_SEL_TIMEOUT_EN undefined:
//    - No counter logic is built and timeout is tied 0.
//    - The grant is held indefinitely until done or the request drops.
// TESTING
//  1. rst_n=0 while req0=req1=1 -> s=0, gnt0=gnt1=0, busy=0 immediately. Release -> gnt0=1 one cycle later.
//  2. From IDLE, req0=1 at edge N -> gnt0=1, s=0 at N+1. Then done=1 at edge M, req0=0 -> gnt0=0, busy=0 at M+1, s stays 0.
//  3. req0=req1=1 held, done pulsed every 3rd cycle -> grants alternate 0,1,0,1.
//     s tracks the owner. busy never drops between owners.
//  4. OWN1 with req1=1, req0=0, done=1 -> re-grant OWN1: gnt1 stays 1, s stays 1.
//  5. MUX2_SEL_TIMEOUT_EN, HOLD_MAX=15, req0=req1=1, done=0:
//     - gnt0 is forced off 15 cycles after grant, with timeout=1 for exactly 1 cycle.
//     - gnt1=1 and s=1 on the next cycle.
//     - Without the macro, gnt0 stays 1 for 40 cycles and timeout stays 0.
//  6. rst_n pulsed low mid-OWN1 (s=1) -> gnt1, busy, s=0 asynchronously. After release, state is IDLE with last=1.

Source files
------------

// File: rtl/mux2_sel_if.sv
// -----------------------------------------------------------------------------
// mux2_sel_if
// Handshake bundle between the two requesting sources and the round-robin
// arbiter that owns the select line of the downstream 2:1 data mux.
//
// Signals
//   req0, req1 : source 0 / source 1 request the mux
//   done       : current owner has finished its transfer
//   s          : mux select (0 = i0 / source 0, 1 = i1 / source 1)
//   gnt0, gnt1 : ownership flags, never both high
//   busy       : gnt0 | gnt1
//   timeout    : one-cycle pulse on a forced release (0 when not built)
//
// Modports
//   master : request side (drives req0/req1/done, observes grant outputs)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface mux2_sel_if;
    logic req0;
    logic req1;
    logic done;
    logic s;
    logic gnt0;
    logic gnt1;
    logic busy;
    logic timeout;

    modport master (
        output req0, req1, done,
        input  s, gnt0, gnt1, busy, timeout
    );

    modport slave (
        input  req0, req1, done,
        output s, gnt0, gnt1, busy, timeout
    );
endinterface

// File: rtl/mux2_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_sel_arbiter
// Round-robin arbiter for two sources sharing one 2:1 mux. The grant is held
// until the owner finishes (done) or drops its request, so the select never
// changes in the middle of a transfer. When the owner releases while the other
// source is waiting, ownership moves across on the same edge (no idle bubble).
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; outputs clear on assertion
//   bus    : mux2_sel_if.slave (req0, req1, done in; s, gnt0, gnt1, busy,
//            timeout out; all outputs registered)
//
// Parameters
//   HOLD_MAX : longest hold, in cycles, before a forced release
//   CNT_W    : hold-counter width, HOLD_MAX must be below 2**CNT_W
//
// Build option
//   MUX2_SEL_TIMEOUT_EN : when defined, an owner that holds the grant for
//   HOLD_MAX cycles without done is released as if done had been raised, and
//   timeout pulses for that cycle. When undefined no counter is built and
//   timeout is tied low.
// -----------------------------------------------------------------------------
module mux2_sel_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux2_sel_if.slave      bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Reject parameter sets where the counter cannot represent HOLD_MAX
    if ((HOLD_MAX < 1) || (HOLD_MAX >= (1 << CNT_W))) begin : g_bad_cfg
        $error("mux2_sel_arbiter: HOLD_MAX must be in 1 .. 2**CNT_W-1");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_q;
    logic       last_d;
    logic       s_q;
    logic       s_d;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       busy_q;
    logic       own_req_s;
    logic       release_s;
    logic       tmo_hit_s;

`ifdef MUX2_SEL_TIMEOUT_EN
    // The release fires on the cycle at whose end the count reaches HOLD_MAX,
    // so the owner keeps the grant for exactly HOLD_MAX cycles.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             entry_s;
    logic             timeout_q;

    // Forced release: owner still requesting, no done, hold budget used up
    always_comb begin
        if ((state_q != ST_IDLE) && !bus.done && own_req_s && (cnt_q == HOLD_LAST)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Hold counter: clears on every grant (including a re-grant), saturates
    always_comb begin
        entry_s = (state_d != ST_IDLE) && ((state_q == ST_IDLE) || release_s);
        if (entry_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q != ST_IDLE) && (cnt_q != HOLD_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Hold counter and timeout pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= tmo_hit_s;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign tmo_hit_s   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Owner's own request and the combined release event
    always_comb begin
        case (state_q)
            ST_OWN0: own_req_s = bus.req0;
            ST_OWN1: own_req_s = bus.req1;
            default: own_req_s = 1'b0;
        endcase
        release_s = bus.done || !own_req_s || tmo_hit_s;
    end

    // Next-state arbitration; a release hands over before re-granting
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (bus.req0) begin
                    state_d = ST_OWN0;
                end else if (bus.req1) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!release_s) begin
                    state_d = ST_OWN0;
                end else if (bus.req1) begin
                    state_d = ST_OWN1;
                end else if (bus.req0) begin
                    state_d = ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!release_s) begin
                    state_d = ST_OWN1;
                end else if (bus.req0) begin
                    state_d = ST_OWN0;
                end else if (bus.req1) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select and last-owner follow the owner; both hold through IDLE
    always_comb begin
        s_d    = s_q;
        last_d = last_q;
        case (state_d)
            ST_OWN0: begin
                s_d    = 1'b0;
                last_d = 1'b0;
            end
            ST_OWN1: begin
                s_d    = 1'b1;
                last_d = 1'b1;
            end
            default: begin
                s_d    = s_q;
                last_d = last_q;
            end
        endcase
    end

    // State and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            gnt0_q  <= (state_d == ST_OWN0);
            gnt1_q  <= (state_d == ST_OWN1);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.s    = s_q;
    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_sel_arbiter
// Directed bench for mux2_sel_arbiter. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, after the edge settles.
// Expected values are written out by hand for each step.
// -----------------------------------------------------------------------------
module tb_mux2_sel_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    mux2_sel_if bus ();

    mux2_sel_arbiter #(
        .HOLD_MAX (15),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against one hand-written vector
    task automatic expect_out(input string tag, input logic g0, input logic g1,
                              input logic sel, input logic bsy, input logic tmo);
        check_val({tag, ".gnt0"},    {31'd0, bus.gnt0},    {31'd0, g0});
        check_val({tag, ".gnt1"},    {31'd0, bus.gnt1},    {31'd0, g1});
        check_val({tag, ".s"},       {31'd0, bus.s},       {31'd0, sel});
        check_val({tag, ".busy"},    {31'd0, bus.busy},    {31'd0, bsy});
        check_val({tag, ".timeout"}, {31'd0, bus.timeout}, {31'd0, tmo});
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.done = 1'b0;

        // 1: reset with both requesting, then first tie goes to source 0
        step();
        step();
        expect_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        expect_out("first_tie", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: both held, done every third cycle, ownership alternates
        bus.done = 1'b1;
        step();
        expect_out("alt_to1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b0;
        step();
        expect_out("alt_hold1a", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("alt_hold1b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        expect_out("alt_to0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b0;
        step();
        expect_out("alt_hold0a", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("alt_hold0b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        expect_out("alt_to1b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // 4: owner 1 finishes but still requests, other idle -> re-grant
        bus.req0 = 1'b0;
        bus.done = 1'b1;
        step();
        expect_out("regrant1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.done = 1'b0;
        step();
        expect_out("regrant1_hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Owner drops its request -> IDLE, select holds at 1
        bus.req1 = 1'b0;
        step();
        expect_out("drop_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.done = 1'b1;
        step();
        expect_out("done_in_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.done = 1'b0;

        // 2: single request from IDLE, one-cycle latency, then done + drop
        bus.req0 = 1'b1;
        step();
        expect_out("req0_grant", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("req0_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.done = 1'b1;
        bus.req0 = 1'b0;
        step();
        expect_out("req0_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.done = 1'b0;
        step();
        expect_out("idle_s_hold0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Tie from IDLE after source 0 owned last -> source 1 wins
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        expect_out("tie_rr", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // 6: asynchronous reset mid-OWN1, outputs clear before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        expect_out("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        expect_out("post_rst_tie", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: long hold with both requesting and no done
`ifdef MUX2_SEL_TIMEOUT_EN
        for (int k = 1; k < 15; k++) begin
            step();
            expect_out("tmo_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step();
        expect_out("tmo_fire", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        expect_out("tmo_after", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`else
        for (int k = 0; k < 40; k++) begin
            step();
            expect_out("no_tmo_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
